// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures sig_in period in clk cycles, with a sticky timeout
// Define DUTY_MEASURE_EN to also report the high-phase length (hi_cycles); otherwise hi_cycles is 0.
module clock_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             timeout,
    output logic [CNT_W-1:0] hi_cycles
);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT = '1;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_prev;
    logic                   sync_out;
    logic                   rise;
    logic [CNT_W-1:0]       cnt;

    assign sync_out = sync_ff[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff   <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            sync_prev <= sync_out;
        end
    end

    // Edge is checked before the timeout compare so an edge at cnt==TIMEOUT still measures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                        cnt   <= '0;
                    end
                    ARMED: begin
                        if (rise) begin
                            cnt   <= ONE;
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period  <= cnt;
                            valid   <= 1'b1;
                            timeout <= 1'b0;
                            cnt     <= ONE;
                        end else if (cnt == TIMEOUT) begin
                            timeout <= 1'b1;
                            state   <= ARMED;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef DUTY_MEASURE_EN
    logic [CNT_W-1:0] hi_cnt;

    // The edge cycle itself is high, so the count restarts at 1 on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_cnt    <= '0;
            hi_cycles <= '0;
        end else if (!en) begin
            hi_cnt <= '0;
        end else begin
            case (state)
                ARMED: begin
                    if (rise) begin
                        hi_cnt <= ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        hi_cycles <= hi_cnt;
                        hi_cnt    <= ONE;
                    end else if (cnt == TIMEOUT) begin
                        hi_cnt <= '0;
                    end else if (sync_out) begin
                        hi_cnt <= hi_cnt + ONE;
                    end
                end
                default: hi_cnt <= '0;
            endcase
        end
    end
`else
    assign hi_cycles = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - directed self-checking bench for clock_period_meter (CNT_W=8)
module tb_clock_period_meter;

    localparam int W = 8;
`ifdef DUTY_MEASURE_EN
    localparam int DUTY = 1;
`else
    localparam int DUTY = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] hi_cycles;
    logic         valid;
    logic         timeout;

    int n_tests = 0;
    int n_fail = 0;
    int nvalid = 0;
    int cyc_n = 0;
    int last_valid_cyc = 0;
    int nv0 = 0;
    int lv = 0;
    int found = 0;
    int pq[$];
    int exp2[7] = '{20, 10, 10, 20, 30, 30, 30};
    logic [W-1:0] last_period = '0;
    logic [W-1:0] last_hi = '0;

    clock_period_meter #(.CNT_W(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .period    (period),
        .valid     (valid),
        .timeout   (timeout),
        .hi_cycles (hi_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if (valid) begin
            nvalid++;
            pq.push_back(int'(period));
            last_valid_cyc = cyc_n;
            last_period = period;
            last_hi = hi_cycles;
        end
    endtask

    task automatic drive(input int hi, input int lo, input int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            repeat (hi) cyc();
            sig_in = 1'b0;
            repeat (lo) cyc();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_period", 32'(period), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_timeout", 32'(timeout), 0);
        chk("reset_hi", 32'(hi_cycles), 0);
        rst = 1'b0;
        en = 1'b1;
        repeat (3) cyc();

        // 50% duty, period 20
        nvalid = 0;
        drive(10, 10, 1);
        chk("t1_no_valid_first_edge", nvalid, 0);
        drive(10, 10, 2);
        chk("t1_valid_count", nvalid, 2);
        chk("t1_period", 32'(last_period), 20);
        chk("t1_hi", 32'(last_hi), DUTY * 10);

        // period 10, a stretched gap, then period 30
        pq.delete();
        drive(5, 5, 3);
        sig_in = 1'b0;
        repeat (10) cyc();
        drive(15, 15, 3);
        sig_in = 1'b1;
        repeat (5) cyc();
        chk("t2_count", pq.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t2_period_%0d", i), (i < pq.size()) ? pq[i] : -1, exp2[i]);
        end
        chk("t2_hi", 32'(last_hi), DUTY * 15);

        // stuck low: timeout 255 cycles after the last edge
        nv0 = nvalid;
        lv = last_valid_cyc;
        sig_in = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            cyc();
            if (timeout) found = 1;
        end
        chk("t3_timeout_seen", found, 1);
        chk("t3_timeout_delay", cyc_n - lv, 255);
        chk("t3_no_valid", nvalid, nv0);
        chk("t3_period_held", 32'(period), 30);
        repeat (20) cyc();
        chk("t3_timeout_sticky", 32'(timeout), 1);
        drive(5, 5, 1);
        chk("t3_first_edge_keeps_timeout", 32'(timeout), 1);
        chk("t3_first_edge_no_valid", nvalid, nv0);
        sig_in = 1'b1;
        repeat (5) cyc();
        chk("t3_timeout_cleared", 32'(timeout), 0);
        chk("t3_period_10", 32'(last_period), 10);

        // edge exactly at cnt==TIMEOUT is a valid measurement
        sig_in = 1'b0;
        repeat (250) cyc();
        sig_in = 1'b1;
        repeat (5) cyc();
        chk("bnd_period_255", 32'(last_period), 255);
        chk("bnd_no_timeout", 32'(timeout), 0);
        chk("bnd_valid_count", nvalid, nv0 + 2);
        chk("bnd_hi", 32'(last_hi), DUTY * 5);

        // en dropped at cnt=7
        sig_in = 1'b0;
        repeat (4) cyc();
        en = 1'b0;
        nv0 = nvalid;
        drive(5, 5, 2);
        chk("t4_no_valid_disabled", nvalid, nv0);
        chk("t4_period_held", 32'(period), 255);
        chk("t4_timeout_held", 32'(timeout), 0);
        en = 1'b1;
        cyc();
        drive(6, 6, 1);
        chk("t4_rearm_no_valid", nvalid, nv0);
        drive(6, 6, 1);
        chk("t4_rearm_valid", nvalid, nv0 + 1);
        chk("t4_period_12", 32'(last_period), 12);

        // asynchronous reset mid-measurement, then fastest input
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_period", 32'(period), 0);
        chk("t5_rst_valid", 32'(valid), 0);
        chk("t5_rst_timeout", 32'(timeout), 0);
        chk("t5_rst_hi", 32'(hi_cycles), 0);
        sig_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        nv0 = nvalid;
        for (int i = 0; i < 12; i++) begin
            sig_in = ~sig_in;
            cyc();
        end
        chk("t5_min_valid_count", nvalid - nv0, 4);
        chk("t5_min_period", 32'(last_period), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
